writeback_stage: RTL

Final stage of the 5-stage RISC-V pipeline. It is the write side of the register file: it accepts retiring instructions from the MEM stage, waits for outstanding data-memory load responses, and sign- or zero-extends load data by `funct3`. It then drives the register file's `write` / `write_address` / `write_data_in` port for exactly one cycle per retiring instruction. It also keeps a retire counter and a sticky protocol-error flag for debug.

---
 rtl/wb_pkg.sv | 19 +
 rtl/load_extend.sv | 43 ++++
 rtl/writeback_stage.sv | 126 ++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage: FSM state encoding,
// load funct3 codes and the default datapath width.
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    COMMIT   = 2'd2
  } wb_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam int XLEN_DEFAULT = 32;

endpackage

// File: rtl/load_extend.sv
// Combinational load-data extraction: picks the byte/halfword lane addressed
// by the load offset and sign- or zero-extends it according to funct3.
module load_extend
  import wb_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  input  logic [XLEN-1:0] word,
  output logic [XLEN-1:0] result
);

  logic [7:0]  byte_lane [4];
  logic [15:0] half_lane [2];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  for (genvar gi = 0; gi < 4; gi++) begin : g_byte
    assign byte_lane[gi] = word[8*gi +: 8];
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_half
    assign half_lane[gi] = word[16*gi +: 16];
  end

  assign sel_byte = byte_lane[offset];
  assign sel_half = half_lane[offset[1]];

  // Unrecognised codes fall back to a full-word load.
  always_comb begin
    result = word;
    case (funct3)
      F3_LB:   result = {{(XLEN-8){sel_byte[7]}}, sel_byte};
      F3_LBU:  result = {{(XLEN-8){1'b0}}, sel_byte};
      F3_LH:   result = {{(XLEN-16){sel_half[15]}}, sel_half};
      F3_LHU:  result = {{(XLEN-16){1'b0}}, sel_half};
      F3_LW:   result = word;
      default: result = word;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: retires MEM-stage instructions into the register file,
// waiting for load responses. Optional WB_FORWARD_EN adds EX bypass outputs.
module writeback_stage
  import wb_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             reg_write_in,
  input  logic [4:0]       rd_in,
  input  logic             is_load,
  input  logic [2:0]       load_funct3,
  input  logic [XLEN-1:0]  alu_result,
  input  logic             mem_rsp_valid,
  input  logic [XLEN-1:0]  mem_rsp_data,
  output logic             write,
  output logic [4:0]       write_address,
  output logic [XLEN-1:0]  write_data_in,
  output logic [CNT_W-1:0] retire_count,
  output logic             stray_rsp
`ifdef WB_FORWARD_EN
  ,
  output logic             fwd_valid,
  output logic [4:0]       fwd_addr,
  output logic [XLEN-1:0]  fwd_data
`endif
);

  wb_state_t       state_reg, state_next;
  logic [4:0]      pend_rd_reg;
  logic            pend_wr_reg;
  logic [2:0]      pend_f3_reg;
  logic [1:0]      pend_off_reg;
  logic [XLEN-1:0] load_data;
  logic            accept;
  logic            commit_wr;
  logic [4:0]      commit_rd;
  logic [XLEN-1:0] commit_data;

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .funct3 (pend_f3_reg),
    .offset (pend_off_reg),
    .word   (mem_rsp_data),
    .result (load_data)
  );

  assign in_ready = (state_reg != WAIT_MEM);
  assign accept   = in_valid && in_ready;

  // Next state plus the values that will be presented if the next cycle commits.
  always_comb begin
    state_next  = state_reg;
    commit_wr   = 1'b0;
    commit_rd   = '0;
    commit_data = '0;
    case (state_reg)
      IDLE, COMMIT: begin
        if (accept) begin
          if (is_load) begin
            state_next = WAIT_MEM;
          end else begin
            state_next  = COMMIT;
            commit_wr   = reg_write_in;
            commit_rd   = rd_in;
            commit_data = alu_result;
          end
        end else begin
          state_next = IDLE;
        end
      end
      WAIT_MEM: begin
        if (mem_rsp_valid) begin
          state_next  = COMMIT;
          commit_wr   = pend_wr_reg;
          commit_rd   = pend_rd_reg;
          commit_data = load_data;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      write         <= 1'b0;
      write_address <= '0;
      write_data_in <= '0;
      retire_count  <= '0;
      stray_rsp     <= 1'b0;
      pend_rd_reg   <= '0;
      pend_wr_reg   <= 1'b0;
      pend_f3_reg   <= '0;
      pend_off_reg  <= '0;
    end else begin
      state_reg <= state_next;
      write     <= (state_next == COMMIT) && commit_wr && (commit_rd != 5'd0);
      if (state_next == COMMIT) begin
        write_address <= commit_rd;
        write_data_in <= commit_data;
        retire_count  <= retire_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (accept && is_load) begin
        pend_rd_reg  <= rd_in;
        pend_wr_reg  <= reg_write_in;
        pend_f3_reg  <= load_funct3;
        pend_off_reg <= alu_result[1:0];
      end
      // A response is only expected while a load is outstanding.
      if (mem_rsp_valid && (state_reg != WAIT_MEM)) begin
        stray_rsp <= 1'b1;
      end
    end
  end

`ifdef WB_FORWARD_EN
  assign fwd_valid = write;
  assign fwd_addr  = write ? write_address : 5'd0;
  assign fwd_data  = write ? write_data_in : '0;
`endif

endmodule
